// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register followed by the EX-stage operand selection for the
//   5-stage MIPS core. The stage captures decoded operands and control from ID,
//   then forwards results from EX/MEM and MEM/WB into the ALU operands. It also
//   detects load-use hazards, inserts a single bubble for each one, and counts
//   those bubbles in a saturating counter.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   id_*                decoded instruction from ID (operand data, indices, control)
//   exmem_*, memwb_*    writer information from the two downstream stages
//   ext_stall           hold every register in this stage
//   flush               kill the instruction that is entering EX
//   alu_*               operands and control driven straight into the ALU
//   ex_store_data       forwarded rt value, used by stores
//   ex_valid/rd/...     EX-stage status for the downstream stages
//   hazard_stall        load-use hazard: IF/ID must hold during this cycle
//   bubble_cnt          saturating count of load-use bubbles
module id_ex_stage #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int CW   = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [DW-1:0]   id_rs_data,
  input  logic [DW-1:0]   id_rt_data,
  input  logic [DW-1:0]   id_imm,
  input  logic [RW-1:0]   id_rs_addr,
  input  logic [RW-1:0]   id_rt_addr,
  input  logic            id_rt_used,
  input  logic [RW-1:0]   id_rd_addr,
  input  logic [4:0]      id_shamt,
  input  logic [CW-1:0]   id_alu_ctrl,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            exmem_reg_write,
  input  logic [RW-1:0]   exmem_rd,
  input  logic [DW-1:0]   exmem_alu_res,
  input  logic            memwb_reg_write,
  input  logic [RW-1:0]   memwb_rd,
  input  logic [DW-1:0]   memwb_data,
  input  logic            ext_stall,
  input  logic            flush,
  output logic [DW-1:0]   alu_data1,
  output logic [DW-1:0]   alu_data2,
  output logic [4:0]      alu_shamt,
  output logic [CW-1:0]   alu_ctrl,
  output logic [DW-1:0]   ex_store_data,
  output logic            ex_valid,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            hazard_stall,
  output logic [CNTW-1:0] bubble_cnt
);

  // Pipeline registers
  logic            ex_valid_reg;
  logic [RW-1:0]   ex_rs_addr_reg;
  logic [RW-1:0]   ex_rt_addr_reg;
  logic [DW-1:0]   ex_rs_data_reg;
  logic [DW-1:0]   ex_rt_data_reg;
  logic [DW-1:0]   ex_imm_reg;
  logic [RW-1:0]   ex_rd_reg;
  logic [4:0]      ex_shamt_reg;
  logic [CW-1:0]   ex_alu_ctrl_reg;
  logic            ex_alu_src_reg;
  logic            ex_reg_write_reg;
  logic            ex_mem_read_reg;
  logic [CNTW-1:0] bubble_cnt_reg;

  // Operand 0 is rs, operand 1 is rt
  logic [RW-1:0] id_addr   [2];
  logic [DW-1:0] id_data   [2];
  logic [DW-1:0] cap_data  [2];
  logic [RW-1:0] ex_addr   [2];
  logic [DW-1:0] ex_data   [2];
  logic [DW-1:0] fwd_data  [2];

  assign id_addr[0] = id_rs_addr;
  assign id_addr[1] = id_rt_addr;
  assign id_data[0] = id_rs_data;
  assign id_data[1] = id_rt_data;
  assign ex_addr[0] = ex_rs_addr_reg;
  assign ex_addr[1] = ex_rt_addr_reg;
  assign ex_data[0] = ex_rs_data_reg;
  assign ex_data[1] = ex_rt_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      // The register file is written at the same edge where ID is captured,
      // so the value being written back this cycle replaces the stale read.
      assign cap_data[gi] = (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_addr[gi]))
                            ? memwb_data : id_data[gi];

      // The younger result (EX/MEM) takes precedence over MEM/WB. Register $0
      // is never forwarded, which also keeps bubbles (index 0) at zero data.
      assign fwd_data[gi] =
        (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_addr[gi])) ? exmem_alu_res :
        (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_addr[gi])) ? memwb_data :
        ex_data[gi];
    end
  endgenerate

  // A load in EX whose destination is read by the instruction in ID.
  // A flushed ID instruction never needs to wait.
  assign hazard_stall = ex_valid_reg && ex_mem_read_reg && (ex_rd_reg != '0) &&
                        id_valid && !flush &&
                        ((id_rs_addr == ex_rd_reg) || (id_rt_used && (id_rt_addr == ex_rd_reg)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg     <= 1'b0;
      ex_rs_addr_reg   <= '0;
      ex_rt_addr_reg   <= '0;
      ex_rs_data_reg   <= '0;
      ex_rt_data_reg   <= '0;
      ex_imm_reg       <= '0;
      ex_rd_reg        <= '0;
      ex_shamt_reg     <= '0;
      ex_alu_ctrl_reg  <= '0;
      ex_alu_src_reg   <= 1'b0;
      ex_reg_write_reg <= 1'b0;
      ex_mem_read_reg  <= 1'b0;
      bubble_cnt_reg   <= '0;
    end else if (ext_stall) begin
      // Hold everything, including the bubble counter.
    end else if (flush || hazard_stall) begin
      // Bubble: all-zero fields give a harmless ALU op on zero operands.
      ex_valid_reg     <= 1'b0;
      ex_rs_addr_reg   <= '0;
      ex_rt_addr_reg   <= '0;
      ex_rs_data_reg   <= '0;
      ex_rt_data_reg   <= '0;
      ex_imm_reg       <= '0;
      ex_rd_reg        <= '0;
      ex_shamt_reg     <= '0;
      ex_alu_ctrl_reg  <= '0;
      ex_alu_src_reg   <= 1'b0;
      ex_reg_write_reg <= 1'b0;
      ex_mem_read_reg  <= 1'b0;
      // hazard_stall is already low whenever flush is high, so only
      // load-use bubbles are counted here.
      if (hazard_stall && (bubble_cnt_reg != '1)) begin
        bubble_cnt_reg <= bubble_cnt_reg + CNTW'(1);
      end
    end else begin
      ex_valid_reg     <= id_valid;
      ex_rs_addr_reg   <= id_rs_addr;
      ex_rt_addr_reg   <= id_rt_addr;
      ex_rs_data_reg   <= cap_data[0];
      ex_rt_data_reg   <= cap_data[1];
      ex_imm_reg       <= id_imm;
      ex_rd_reg        <= id_rd_addr;
      ex_shamt_reg     <= id_shamt;
      ex_alu_ctrl_reg  <= id_alu_ctrl;
      ex_alu_src_reg   <= id_alu_src;
      ex_reg_write_reg <= id_reg_write && id_valid;
      ex_mem_read_reg  <= id_mem_read && id_valid;
    end
  end

  assign alu_data1     = fwd_data[0];
  assign alu_data2     = ex_alu_src_reg ? ex_imm_reg : fwd_data[1];
  assign ex_store_data = fwd_data[1];
  assign alu_shamt     = ex_shamt_reg;
  assign alu_ctrl      = ex_alu_ctrl_reg;
  assign ex_valid      = ex_valid_reg;
  assign ex_rd         = ex_rd_reg;
  assign ex_reg_write  = ex_reg_write_reg && ex_valid_reg;
  assign ex_mem_read   = ex_mem_read_reg && ex_valid_reg;
  assign bubble_cnt    = bubble_cnt_reg;

endmodule
